// File: rtl/ac97_pkg.sv
// Shared constants for the AC97 command scheduler: codec register indices,
// the power-up init ROM and the scheduler state encoding.
package ac97_pkg;

   localparam logic [6:0] MASTER_VOL  = 7'h02;
   localparam logic [6:0] PCM_OUT_VOL = 7'h18;
   localparam logic [6:0] REC_SEL     = 7'h1A;
   localparam logic [6:0] LINE_IN_VOL = 7'h10;

   localparam int unsigned INIT_LEN = 4;

   localparam logic [1:0] StWaitRdy  = 2'd0;
   localparam logic [1:0] StInit     = 2'd1;
   localparam logic [1:0] StIdle     = 2'd2;
   localparam logic [1:0] StWaitStat = 2'd3;

   typedef struct packed {
      logic [6:0]  addr;
      logic [15:0] data;
   } init_entry_t;

   function automatic init_entry_t init_entry(input logic [2:0] idx);
      init_entry_t e;
      case (idx)
         3'd0:    e = '{addr: MASTER_VOL,  data: 16'h0000};
         3'd1:    e = '{addr: PCM_OUT_VOL, data: 16'h0808};
         3'd2:    e = '{addr: REC_SEL,     data: 16'h0404};
         3'd3:    e = '{addr: LINE_IN_VOL, data: 16'h0808};
         default: e = '{addr: 7'h00,       data: 16'h0000};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/ac97_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after ptr_i,
// wrapping around to index 0.
module ac97_rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IdxW    = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IdxW-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IdxW-1:0]    idx_o,
   output logic               any_o
);

   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      // First pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_i[i] && (i >= int'(ptr_i))) begin
            found    = 1'b1;
            gnt_o[i] = 1'b1;
            idx_o    = IdxW'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_i[i]) begin
            found    = 1'b1;
            gnt_o[i] = 1'b1;
            idx_o    = IdxW'(i);
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/ac97_cmd_scheduler.sv
// AC97 command slot scheduler: codec power-up init, round-robin sharing of the
// per-frame command slot, and read-status return routing with timeout.
module ac97_cmd_scheduler
   import ac97_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned TIMEOUT_FRAMES = 4
) (
   input  logic                  fclk,
   input  logic                  freset,
   input  logic                  fFrameStart,
   input  logic                  fCodecReady,
   input  logic                  fStatValid,
   input  logic [6:0]            fStatAddr,
   input  logic [15:0]           fStatData,
   output logic                  fCmdValid,
   output logic                  fCmdRead,
   output logic [6:0]            fCmdAddr,
   output logic [15:0]           fCmdData,
   input  logic [NUM_REQ-1:0]    fReq,
   input  logic [NUM_REQ-1:0]    fReqRead,
   input  logic [7*NUM_REQ-1:0]  fReqAddr,
   input  logic [16*NUM_REQ-1:0] fReqData,
   output logic [NUM_REQ-1:0]    fAck,
   output logic [NUM_REQ-1:0]    fRdValid,
   output logic [15:0]           fRdData,
   output logic                  fInitDone,
   output logic                  fTimeout
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned TmoW = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_REQ - 1);
   localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_FRAMES - 1);
   localparam logic [2:0]      InitLast = 3'(INIT_LEN);

   logic [1:0]         state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [IdxW-1:0]    ptr_q, ptr_d;
   logic [TmoW-1:0]    tcnt_q, tcnt_d;
   logic [6:0]         pend_addr_q, pend_addr_d;
   logic [IdxW-1:0]    pend_g_q, pend_g_d;
   logic               cmd_valid_q, cmd_valid_d;
   logic               cmd_read_q, cmd_read_d;
   logic [6:0]         cmd_addr_q, cmd_addr_d;
   logic [15:0]        cmd_data_q, cmd_data_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
   logic [15:0]        rd_data_q, rd_data_d;
   logic               init_done_q, init_done_d;
   logic               timeout_q, timeout_d;

   logic [NUM_REQ-1:0] gnt;
   logic [IdxW-1:0]    gnt_idx;
   logic               gnt_any;
   logic               stat_hit;
   logic [NUM_REQ-1:0] pend_onehot;
   init_entry_t        rom;

   ac97_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IdxW    (IdxW)
   ) u_arb (
      .req_i (fReq),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   assign stat_hit    = fStatValid && (fStatAddr == pend_addr_q);
   assign pend_onehot = NUM_REQ'(1) << pend_g_q;
   assign rom         = init_entry(idx_q);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      ptr_d       = ptr_q;
      tcnt_d      = tcnt_q;
      pend_addr_d = pend_addr_q;
      pend_g_d    = pend_g_q;
      cmd_valid_d = cmd_valid_q;
      cmd_read_d  = cmd_read_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_data_d  = cmd_data_q;
      ack_d       = '0;
      rd_valid_d  = '0;
      rd_data_d   = rd_data_q;
      init_done_d = init_done_q;
      timeout_d   = 1'b0;

      // Losing codec ready overrides everything, including a coincident status match.
      if (fFrameStart && (state_q != StWaitRdy) && !fCodecReady) begin
         {cmd_valid_d, cmd_read_d, cmd_addr_d, cmd_data_d} = '0;
         init_done_d = 1'b0;
         idx_d       = '0;
         state_d     = StWaitRdy;
         if (state_q == StWaitStat) begin
            rd_data_d  = 16'hFFFF;
            rd_valid_d = pend_onehot;
            timeout_d  = 1'b1;
         end
      end else begin
         case (state_q)
            StWaitRdy: begin
               if (fFrameStart && fCodecReady) begin
                  idx_d   = '0;
                  state_d = StInit;
               end
            end
            StInit: begin
               if (fFrameStart) begin
                  if (idx_q < InitLast) begin
                     cmd_valid_d = 1'b1;
                     cmd_read_d  = 1'b0;
                     cmd_addr_d  = rom.addr;
                     cmd_data_d  = rom.data;
                     idx_d       = idx_q + 3'd1;
                  end else begin
                     {cmd_valid_d, cmd_read_d, cmd_addr_d, cmd_data_d} = '0;
                     init_done_d = 1'b1;
                     state_d     = StIdle;
                  end
               end
            end
            StIdle: begin
               if (fFrameStart) begin
                  if (gnt_any) begin
                     ack_d       = gnt;
                     cmd_valid_d = 1'b1;
                     cmd_read_d  = fReqRead[gnt_idx];
                     cmd_addr_d  = fReqAddr[7*int'(gnt_idx) +: 7];
                     cmd_data_d  = fReqRead[gnt_idx] ? 16'h0000
                                                     : fReqData[16*int'(gnt_idx) +: 16];
                     ptr_d       = (gnt_idx == LastIdx) ? '0 : gnt_idx + IdxW'(1);
                     if (fReqRead[gnt_idx]) begin
                        pend_addr_d = fReqAddr[7*int'(gnt_idx) +: 7];
                        pend_g_d    = gnt_idx;
                        tcnt_d      = '0;
                        state_d     = StWaitStat;
                     end
                  end else begin
                     {cmd_valid_d, cmd_read_d, cmd_addr_d, cmd_data_d} = '0;
                  end
               end
            end
            default: begin
               if (fFrameStart) begin
                  {cmd_valid_d, cmd_read_d, cmd_addr_d, cmd_data_d} = '0;
               end
               if (stat_hit) begin
                  rd_data_d  = fStatData;
                  rd_valid_d = pend_onehot;
                  state_d    = StIdle;
               end else if (fFrameStart) begin
                  tcnt_d = tcnt_q + TmoW'(1);
                  if (tcnt_q == TmoLast) begin
                     rd_data_d  = 16'hFFFF;
                     rd_valid_d = pend_onehot;
                     timeout_d  = 1'b1;
                     state_d    = StIdle;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge fclk or posedge freset) begin
      if (freset) begin
         state_q     <= StWaitRdy;
         idx_q       <= '0;
         ptr_q       <= '0;
         tcnt_q      <= '0;
         pend_addr_q <= '0;
         pend_g_q    <= '0;
         cmd_valid_q <= 1'b0;
         cmd_read_q  <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_data_q  <= '0;
         ack_q       <= '0;
         rd_valid_q  <= '0;
         rd_data_q   <= '0;
         init_done_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         ptr_q       <= ptr_d;
         tcnt_q      <= tcnt_d;
         pend_addr_q <= pend_addr_d;
         pend_g_q    <= pend_g_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_read_q  <= cmd_read_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_data_q  <= cmd_data_d;
         ack_q       <= ack_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         init_done_q <= init_done_d;
         timeout_q   <= timeout_d;
      end
   end

   assign fCmdValid = cmd_valid_q;
   assign fCmdRead  = cmd_read_q;
   assign fCmdAddr  = cmd_addr_q;
   assign fCmdData  = cmd_data_q;
   assign fAck      = ack_q;
   assign fRdValid  = rd_valid_q;
   assign fRdData   = rd_data_q;
   assign fInitDone = init_done_q;
   assign fTimeout  = timeout_q;

endmodule

// File: tb/tb_ac97_cmd_scheduler.sv
// Bench for ac97_cmd_scheduler: init table, directed corner sequences and a
// randomized phase, all cross-checked every cycle against a frame-level model.
module tb_ac97_cmd_scheduler;

   localparam int NR    = 2;
   localparam int TO    = 4;
   localparam int FRAME = 8;

   logic              fclk = 1'b0;
   logic              freset;
   logic              fFrameStart = 1'b0;
   logic              fCodecReady = 1'b0;
   logic              fStatValid  = 1'b0;
   logic [6:0]        fStatAddr   = '0;
   logic [15:0]       fStatData   = '0;
   logic              fCmdValid, fCmdRead;
   logic [6:0]        fCmdAddr;
   logic [15:0]       fCmdData;
   logic [NR-1:0]     fReq     = '0;
   logic [NR-1:0]     fReqRead = '0;
   logic [7*NR-1:0]   fReqAddr = '0;
   logic [16*NR-1:0]  fReqData = '0;
   logic [NR-1:0]     fAck, fRdValid;
   logic [15:0]       fRdData;
   logic              fInitDone, fTimeout;

   ac97_cmd_scheduler #(
      .NUM_REQ        (NR),
      .TIMEOUT_FRAMES (TO)
   ) dut (
      .fclk        (fclk),
      .freset      (freset),
      .fFrameStart (fFrameStart),
      .fCodecReady (fCodecReady),
      .fStatValid  (fStatValid),
      .fStatAddr   (fStatAddr),
      .fStatData   (fStatData),
      .fCmdValid   (fCmdValid),
      .fCmdRead    (fCmdRead),
      .fCmdAddr    (fCmdAddr),
      .fCmdData    (fCmdData),
      .fReq        (fReq),
      .fReqRead    (fReqRead),
      .fReqAddr    (fReqAddr),
      .fReqData    (fReqData),
      .fAck        (fAck),
      .fRdValid    (fRdValid),
      .fRdData     (fRdData),
      .fInitDone   (fInitDone),
      .fTimeout    (fTimeout)
   );

   always #5 fclk = ~fclk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   typedef struct {
      int         req;
      logic [6:0] addr;
      int         frames;
   } pend_t;

   logic [6:0]  rom_a [4] = '{7'h02, 7'h18, 7'h1A, 7'h10};
   logic [15:0] rom_d [4] = '{16'h0000, 16'h0808, 16'h0404, 16'h0808};

   pend_t       pend[$];
   int          m_pos;   // -1: waiting for codec, 0..4: init entries issued
   int          m_ptr;
   logic        m_done, m_valid, m_read, m_to;
   logic [6:0]  m_addr;
   logic [15:0] m_data, m_rdata;
   logic [NR-1:0] m_ack, m_rdv;
   logic        hit, granted;

   task automatic m_clear();
      m_valid = 1'b0; m_read = 1'b0; m_addr = '0; m_data = '0;
   endtask

   task automatic m_finish(input logic [15:0] d, input logic tmo);
      m_rdata = d;
      m_rdv   = NR'(1) << pend[0].req;
      m_to    = tmo;
      void'(pend.pop_front());
   endtask

   always @(posedge fclk or posedge freset) begin
      m_ack = '0; m_rdv = '0; m_to = 1'b0;
      if (freset) begin
         m_pos = -1; m_ptr = 0; m_done = 1'b0; m_rdata = '0;
         m_clear();
         pend.delete();
      end else begin
         hit = fStatValid && (pend.size() > 0) && (fStatAddr == pend[0].addr);
         if (fFrameStart) begin
            if (m_pos >= 0 && !fCodecReady) begin
               if (pend.size() > 0) m_finish(16'hFFFF, 1'b1);
               m_clear();
               m_done = 1'b0;
               m_pos  = -1;
            end else if (m_pos < 0) begin
               if (fCodecReady) m_pos = 0;
            end else if (m_pos < 4) begin
               m_valid = 1'b1; m_read = 1'b0;
               m_addr = rom_a[m_pos]; m_data = rom_d[m_pos];
               m_pos++;
            end else if (!m_done) begin
               m_clear();
               m_done = 1'b1;
            end else if (pend.size() > 0) begin
               m_clear();
               if (hit) m_finish(fStatData, 1'b0);
               else begin
                  pend[0].frames++;
                  if (pend[0].frames == TO) m_finish(16'hFFFF, 1'b1);
               end
            end else begin
               m_clear();
               granted = 1'b0;
               for (int k = 0; k < NR; k++) begin
                  int i;
                  i = (m_ptr + k) % NR;
                  if (!granted && fReq[i]) begin
                     granted  = 1'b1;
                     m_ack[i] = 1'b1;
                     m_valid  = 1'b1;
                     m_read   = fReqRead[i];
                     m_addr   = fReqAddr[7*i +: 7];
                     m_data   = fReqRead[i] ? 16'h0000 : fReqData[16*i +: 16];
                     m_ptr    = (i + 1) % NR;
                     if (fReqRead[i]) pend.push_back('{i, fReqAddr[7*i +: 7], 0});
                  end
               end
            end
         end else if (hit) begin
            m_finish(fStatData, 1'b0);
         end
      end
   end

   always @(negedge fclk) begin
      chk("valid", 32'(fCmdValid), 32'(m_valid));
      if (m_valid) chk("cmd", 32'({fCmdRead, fCmdAddr, fCmdData}), 32'({m_read, m_addr, m_data}));
      chk("ack", 32'(fAck), 32'(m_ack));
      chk("rd", 32'({fRdValid, fRdData}), 32'({m_rdv, m_rdata}));
      chk("flags", 32'({fInitDone, fTimeout}), 32'({m_done, m_to}));
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic        ready;
      logic        valid;
      logic [6:0]  addr;
      logic [15:0] data;
      logic        done;
   } init_vec_t;

   init_vec_t iv [9];

   task automatic step();
      @(posedge fclk);
      #1;
   endtask

   task automatic do_frame();
      fFrameStart = 1'b1;
      step();
      fFrameStart = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic run_init(input int first);
      for (int i = first; i < 9; i++) begin
         fCodecReady = iv[i].ready;
         do_frame();
         chk("init_valid", 32'(fCmdValid), 32'(iv[i].valid));
         chk("init_done", 32'(fInitDone), 32'(iv[i].done));
         if (iv[i].valid)
            chk("init_cmd", 32'({fCmdRead, fCmdAddr, fCmdData}), 32'({1'b0, iv[i].addr, iv[i].data}));
         idle(FRAME - 1);
      end
   endtask

   initial begin
      iv[0] = '{1'b0, 1'b0, 7'h00, 16'h0000, 1'b0};
      iv[1] = '{1'b0, 1'b0, 7'h00, 16'h0000, 1'b0};
      iv[2] = '{1'b0, 1'b0, 7'h00, 16'h0000, 1'b0};
      iv[3] = '{1'b1, 1'b0, 7'h00, 16'h0000, 1'b0};
      iv[4] = '{1'b1, 1'b1, 7'h02, 16'h0000, 1'b0};
      iv[5] = '{1'b1, 1'b1, 7'h18, 16'h0808, 1'b0};
      iv[6] = '{1'b1, 1'b1, 7'h1A, 16'h0404, 1'b0};
      iv[7] = '{1'b1, 1'b1, 7'h10, 16'h0808, 1'b0};
      iv[8] = '{1'b1, 1'b0, 7'h00, 16'h0000, 1'b1};

      freset = 1'b1;
      idle(2);
      chk("reset_cmd", 32'({fCmdValid, fCmdRead, fCmdAddr, fCmdData}), 32'd0);
      chk("reset_misc", 32'({fAck, fRdValid, fRdData, fInitDone, fTimeout}), 32'd0);
      freset = 1'b0;
      idle(3);
      run_init(0);

      // Two simultaneous writes: req0 this frame, req1 the next.
      fReq = 2'b11; fReqRead = 2'b00;
      fReqAddr = {7'h04, 7'h02}; fReqData = {16'h0000, 16'h1F1F};
      idle(FRAME - 1);
      do_frame();
      chk("w0_ack", 32'(fAck), 32'(2'b01));
      chk("w0_cmd", 32'({fCmdValid, fCmdRead, fCmdAddr, fCmdData}), 32'({1'b1, 1'b0, 7'h02, 16'h1F1F}));
      fReq[0] = 1'b0;
      step();
      chk("w0_ack_pulse", 32'(fAck), 32'd0);
      idle(FRAME - 2);
      do_frame();
      chk("w1_ack", 32'(fAck), 32'(2'b10));
      chk("w1_cmd", 32'({fCmdValid, fCmdRead, fCmdAddr, fCmdData}), 32'({1'b1, 1'b0, 7'h04, 16'h0000}));
      fReq = 2'b00;
      idle(FRAME - 1);

      // Req1 read with a mismatched then matching status; req0 waits.
      fReq = 2'b10; fReqRead = 2'b10;
      fReqAddr = {7'h26, 7'h00}; fReqData = {16'hBEEF, 16'h0000};
      do_frame();
      chk("r1_ack", 32'(fAck), 32'(2'b10));
      chk("r1_cmd", 32'({fCmdValid, fCmdRead, fCmdAddr, fCmdData}), 32'({1'b1, 1'b1, 7'h26, 16'h0000}));
      fReq = 2'b01; fReqRead = 2'b00;
      fReqAddr = {7'h00, 7'h08}; fReqData = {16'h0000, 16'h1234};
      idle(FRAME - 1);
      do_frame();
      chk("r1_hold_ack", 32'(fAck), 32'd0);
      chk("r1_slot_idle", 32'(fCmdValid), 32'd0);
      fStatValid = 1'b1; fStatAddr = 7'h27; fStatData = 16'h5555;
      step();
      chk("r1_mismatch", 32'(fRdValid), 32'd0);
      fStatAddr = 7'h26; fStatData = 16'h000F;
      step();
      fStatValid = 1'b0;
      chk("r1_return", 32'({fRdValid, fRdData}), 32'({2'b10, 16'h000F}));
      step();
      chk("r1_rdv_pulse", 32'(fRdValid), 32'd0);
      idle(FRAME - 4);
      do_frame();
      chk("w0b_ack", 32'(fAck), 32'(2'b01));
      chk("w0b_cmd", 32'({fCmdValid, fCmdRead, fCmdAddr, fCmdData}), 32'({1'b1, 1'b0, 7'h08, 16'h1234}));
      fReq = 2'b00;
      idle(FRAME - 1);

      // Read with no status returns 0xFFFF after TO frames.
      fReq = 2'b01; fReqRead = 2'b01; fReqAddr = {7'h00, 7'h7C};
      do_frame();
      chk("to_ack", 32'(fAck), 32'(2'b01));
      chk("to_cmd", 32'({fCmdValid, fCmdRead, fCmdAddr}), 32'({1'b1, 1'b1, 7'h7C}));
      fReq = 2'b00;
      idle(FRAME - 1);
      for (int f = 1; f <= TO; f++) begin
         do_frame();
         chk("to_flag", 32'(fTimeout), 32'(f == TO));
         chk("to_rdv", 32'(fRdValid), (f == TO) ? 32'(2'b01) : 32'd0);
         chk("to_slot", 32'(fCmdValid), 32'd0);
         if (f == TO) chk("to_data", 32'(fRdData), 32'hFFFF);
         idle(FRAME - 1);
      end

      // Codec ready lost during a pending read.
      fReq = 2'b10; fReqRead = 2'b10; fReqAddr = {7'h30, 7'h00};
      do_frame();
      chk("cd_ack", 32'(fAck), 32'(2'b10));
      fReq = 2'b00;
      idle(FRAME - 1);
      fCodecReady = 1'b0;
      do_frame();
      chk("cd_rd", 32'({fRdValid, fRdData}), 32'({2'b10, 16'hFFFF}));
      chk("cd_flags", 32'({fCmdValid, fInitDone, fTimeout}), 32'({1'b0, 1'b0, 1'b1}));
      idle(FRAME - 1);
      fCodecReady = 1'b1;
      do_frame();
      chk("cd_wait", 32'(fCmdValid), 32'd0);
      idle(FRAME - 1);
      do_frame();
      chk("cd_rerun", 32'({fCmdValid, fCmdAddr, fCmdData}), 32'({1'b1, 7'h02, 16'h0000}));

      // Asynchronous reset in the middle of an init frame.
      idle(2);
      #2;
      freset = 1'b1;
      #1;
      chk("mid_rst_cmd", 32'({fCmdValid, fCmdRead, fCmdAddr, fCmdData}), 32'd0);
      chk("mid_rst_misc", 32'({fAck, fRdValid, fRdData, fInitDone, fTimeout}), 32'd0);
      step();
      freset = 1'b0;
      idle(2);
      run_init(3);

      // Randomized traffic; the model checks every cycle.
      for (int f = 0; f < 150; f++) begin
         fCodecReady = ($urandom_range(0, 29) != 0);
         for (int c = 0; c < FRAME; c++) begin
            fFrameStart = (c == 0);
            fStatValid  = ($urandom_range(0, 4) == 0);
            fStatAddr   = ($urandom_range(0, 1) == 1 && pend.size() > 0) ? pend[0].addr
                                                                         : 7'($urandom);
            fStatData   = 16'($urandom);
            step();
            for (int i = 0; i < NR; i++) begin
               if (fAck[i]) fReq[i] = 1'b0;
               else if (!fReq[i] && $urandom_range(0, 3) == 0) begin
                  fReq[i]             = 1'b1;
                  fReqRead[i]         = 1'($urandom_range(0, 1));
                  fReqAddr[7*i +: 7]  = 7'($urandom);
                  fReqData[16*i +: 16] = 16'($urandom);
               end else if (fReq[i] && $urandom_range(0, 39) == 0) fReq[i] = 1'b0;
            end
         end
      end
      fFrameStart = 1'b0; fStatValid = 1'b0; fReq = '0;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
